aes_selftest_seq: RTL and testbench

AES_SELFTEST_SEQ -- requirements
Module: aes_selftest_seq

---
 rtl/aes_seq_pkg.sv | 37 +++
 rtl/seg7_decoder.sv | 15 +
 rtl/aes_selftest_seq.sv | 168 ++++++++++++++++
 tb/tb_aes_selftest_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - shared states, mode codes, round count helper and 7-segment glyphs
package aes_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_e;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_ENC  = 2'd1;
  localparam logic [1:0] MODE_DEC  = 2'd2;
  localparam logic [1:0] MODE_RT   = 2'd3;

  // Glyph codes 0..15 are hex digits; two extra codes select 'P' and blank.
  localparam logic [4:0] CODE_F     = 5'd15;
  localparam logic [4:0] CODE_P     = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] GLYPH_P     = 7'h0C;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int nr_of(input int key_bits);
    if (key_bits == 256) return 14;
    else if (key_bits == 192) return 12;
    else return 10;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - glyph code to active-low 7-segment pattern
module seg7_decoder
  import aes_seq_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_BLANK;
    if (code_i < 5'd16) seg_o = GLYPH_HEX[code_i[3:0]];
    else if (code_i == CODE_P) seg_o = GLYPH_P;
  end

endmodule

// File: rtl/aes_selftest_seq.sv
// rtl/aes_selftest_seq.sv - AES known-answer self-test sequencer with optional 7-segment status
// Display decoder built only when AES_SEG_DISPLAY_EN is defined.
module aes_selftest_seq
  import aes_seq_pkg::*;
#(
  parameter int KEY_BITS    = 128,
  parameter int NUM_VECTORS = 4,
  parameter int NUM_DIGITS  = 6,
  localparam int VW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    start,
  input  logic                    dp_match,
  output logic                    load,
  output logic                    rnd_en,
  output logic [3:0]              rnd_idx,
  output logic                    dec,
  output logic [VW-1:0]           vec_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    assert_o,
  output logic [4:0]              fail_cnt,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam logic [3:0]    NR       = 4'(nr_of(KEY_BITS));
  localparam logic [VW-1:0] LAST_VEC = VW'(NUM_VECTORS - 1);

  state_e        state_q;
  logic [1:0]    mode_q;
  logic          load_q, rnd_en_q, dec_q, busy_q, done_q, pass_q;
  logic [3:0]    rnd_idx_q;
  logic [VW-1:0] vec_idx_q;
  logic [4:0]    fail_cnt_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_IDLE;
      load_q     <= 1'b0;
      rnd_en_q   <= 1'b0;
      rnd_idx_q  <= '0;
      dec_q      <= 1'b0;
      vec_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      load_q   <= 1'b0;
      rnd_en_q <= 1'b0;
      if (busy_q && mode != mode_q) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        rnd_idx_q  <= '0;
        dec_q      <= 1'b0;
        vec_idx_q  <= '0;
        fail_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start && mode != MODE_IDLE) begin
              state_q    <= S_LOAD;
              mode_q     <= mode;
              load_q     <= 1'b1;
              rnd_idx_q  <= '0;
              dec_q      <= 1'b0;
              vec_idx_q  <= '0;
              fail_cnt_q <= '0;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              pass_q     <= 1'b0;
            end else if (mode == MODE_IDLE) begin
              state_q <= S_IDLE;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
          S_LOAD: begin
            state_q   <= S_ROUND;
            rnd_en_q  <= 1'b1;
            rnd_idx_q <= '0;
            dec_q     <= (mode_q == MODE_DEC);
          end
          S_ROUND: begin
            if (rnd_idx_q != NR) begin
              rnd_idx_q <= rnd_idx_q + 4'd1;
              rnd_en_q  <= 1'b1;
            end else if (mode_q == MODE_RT && !dec_q) begin
              // Round trip: inverse pass follows directly on the same loaded block.
              rnd_idx_q <= '0;
              dec_q     <= 1'b1;
              rnd_en_q  <= 1'b1;
            end else begin
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (!dp_match && fail_cnt_q != 5'd31) fail_cnt_q <= fail_cnt_q + 5'd1;
            state_q <= S_NEXT;
          end
          S_NEXT: begin
            if (vec_idx_q == LAST_VEC) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_cnt_q == 5'd0);
            end else begin
              state_q   <= S_LOAD;
              vec_idx_q <= vec_idx_q + VW'(1);
              load_q    <= 1'b1;
              rnd_idx_q <= '0;
              dec_q     <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign load     = load_q;
  assign rnd_en   = rnd_en_q;
  assign rnd_idx  = rnd_idx_q;
  assign dec      = dec_q;
  assign vec_idx  = vec_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign assert_o = pass_q;
  assign fail_cnt = fail_cnt_q;

`ifdef AES_SEG_DISPLAY_EN
  logic [5*NUM_DIGITS-1:0] codes;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic [7*NUM_DIGITS-1:0] seg_q;
  logic [3:0]              vec4;

  always_comb begin
    vec4 = '0;
    vec4[VW-1:0] = vec_idx_q;
    for (int g = 0; g < NUM_DIGITS; g++) codes[g*5 +: 5] = CODE_BLANK;
    codes[4:0]   = (rnd_idx_q >= 4'd10) ? {1'b0, rnd_idx_q - 4'd10} : {1'b0, rnd_idx_q};
    codes[9:5]   = (rnd_idx_q >= 4'd10) ? 5'd1 : 5'd0;
    codes[14:10] = {1'b0, vec4};
    codes[19:15] = done_q ? (pass_q ? CODE_P : CODE_F) : CODE_BLANK;
    if (NUM_DIGITS > 4) codes[(NUM_DIGITS-1)*5 +: 5] = {3'b000, mode};
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_decoder u_dec (
      .code_i (codes[g*5 +: 5]),
      .seg_o  (seg_d[g*7 +: 7])
    );
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) seg_q <= '1;
    else       seg_q <= seg_d;
  end

  assign seg = seg_q;
`else
  assign seg = '1;
`endif

endmodule

// File: tb/tb_aes_selftest_seq.sv
// tb/tb_aes_selftest_seq.sv - directed self-checking bench for aes_selftest_seq
module tb_aes_selftest_seq;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        start = 1'b0;
  logic        dp_match = 1'b1;
  logic        load, rnd_en, dec, busy, done, assert_o;
  logic [3:0]  rnd_idx;
  logic [1:0]  vec_idx;
  logic [4:0]  fail_cnt;
  logic [41:0] seg;

  logic [1:0]  mode2 = 2'd0;
  logic        start2 = 1'b0;
  logic        load2, rnd_en2, dec2, busy2, done2, assert2;
  logic [3:0]  rnd_idx2;
  logic [0:0]  vec_idx2;
  logic [4:0]  fail_cnt2;
  logic [41:0] seg2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [41:0] SEG_BLANK = {42{1'b1}};

  always #5 CLK = ~CLK;

  aes_selftest_seq #(.KEY_BITS(128), .NUM_VECTORS(4), .NUM_DIGITS(6)) dut (
    .CLK(CLK), .reset(reset), .mode(mode), .start(start), .dp_match(dp_match),
    .load(load), .rnd_en(rnd_en), .rnd_idx(rnd_idx), .dec(dec), .vec_idx(vec_idx),
    .busy(busy), .done(done), .assert_o(assert_o), .fail_cnt(fail_cnt), .seg(seg)
  );

  aes_selftest_seq #(.KEY_BITS(256), .NUM_VECTORS(1), .NUM_DIGITS(6)) dut2 (
    .CLK(CLK), .reset(reset), .mode(mode2), .start(start2), .dp_match(1'b1),
    .load(load2), .rnd_en(rnd_en2), .rnd_idx(rnd_idx2), .dec(dec2), .vec_idx(vec_idx2),
    .busy(busy2), .done(done2), .assert_o(assert2), .fail_cnt(fail_cnt2), .seg(seg2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, rn, ln, bad_dec, k;
    logic seen, found, any_done;

    // Reset state
    #2;
    check("rst_outputs", {load, rnd_en, rnd_idx, dec, vec_idx, busy, done, assert_o, fail_cnt}, '0);
    check("rst_seg", seg, SEG_BLANK);
    tick();
    reset = 1'b0;
    tick();

    // start with mode 0 is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_mode0_busy", {busy, load}, 2'b00);

    // Encrypt, all vectors match; a start pulse mid-run must be ignored
    mode = 2'd1; dp_match = 1'b1; start = 1'b1;
    n = 0; rn = 0; ln = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      start = (n == 20);
      if (rnd_en) rn++;
      if (load) ln++;
      if (n == 1) check("enc_first_load", {load, busy, rnd_idx}, {1'b1, 1'b1, 4'd0});
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("enc_latency", n, 57);
    check("enc_rnd_en_cycles", rn, 44);
    check("enc_load_pulses", ln, 4);
    check("enc_result", {done, assert_o, busy, fail_cnt}, {1'b1, 1'b1, 1'b0, 5'd0});
    tick();
    check("enc_done_held", done, 1'b1);
`ifdef AES_SEG_DISPLAY_EN
    check("enc_seg", seg, {7'h79, 7'h7F, 7'h0C, 7'h30, 7'h79, 7'h40});
`else
    check("enc_seg", seg, SEG_BLANK);
`endif

    // mode 0 from DONE returns to idle
    mode = 2'd0;
    tick();
    check("done_to_idle", {done, busy}, 2'b00);

    // Decrypt with mismatches on vectors 1 and 3
    mode = 2'd2; dp_match = 1'b1; start = 1'b1;
    n = 0; bad_dec = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      start = 1'b0;
      if (rnd_en && !dec) bad_dec++;
      dp_match = !(vec_idx == 2'd1 || vec_idx == 2'd3);
      if (done) seen = 1'b1;
    end
    check("dec_latency", n, 57);
    check("dec_flag", bad_dec, 0);
    check("dec_result", {done, assert_o, fail_cnt}, {1'b1, 1'b0, 5'd2});
    tick();
`ifdef AES_SEG_DISPLAY_EN
    check("dec_seg", seg, {7'h24, 7'h7F, 7'h0E, 7'h30, 7'h79, 7'h40});
`else
    check("dec_seg", seg, SEG_BLANK);
`endif

    // start from DONE begins a fresh run
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart", {load, busy, done, fail_cnt, vec_idx}, {1'b1, 1'b1, 1'b0, 5'd0, 2'd0});
    mode = 2'd0;
    tick();
    check("abort_to_idle", {busy, load, rnd_en}, 3'b000);

    // Mode change 1->2 during ROUND of vector 2 aborts
    mode = 2'd1; dp_match = 1'b0; start = 1'b1;
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      tick();
      n++;
      start = 1'b0;
      if (vec_idx == 2'd2 && rnd_en && rnd_idx == 4'd4) found = 1'b1;
    end
    check("abort_reach", found, 1'b1);
    check("abort_pre_fail", fail_cnt, 5'd2);
    mode = 2'd2;
    tick();
    check("abort_state", {busy, done, fail_cnt, vec_idx, rnd_en}, {1'b0, 1'b0, 5'd0, 2'd0, 1'b0});
    any_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || busy) any_done = 1'b1;
    end
    check("abort_no_done", any_done, 1'b0);

    // Asynchronous reset mid-ROUND
    mode = 2'd1; dp_match = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_round", {rnd_en, busy}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("async_rst_outputs", {load, rnd_en, rnd_idx, dec, vec_idx, busy, done, assert_o, fail_cnt}, '0);
    check("async_rst_seg", seg, SEG_BLANK);
    tick();
    reset = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || busy) any_done = 1'b1;
    end
    check("rst_no_done", any_done, 1'b0);

    // Round trip, 256-bit key, single vector
    mode2 = 2'd3; start2 = 1'b1;
    n = 0; k = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      start2 = 1'b0;
      if (rnd_en2) begin
        if (k < 30)
          check($sformatf("rt_round_%0d", k), {dec2, rnd_idx2},
                (k < 15) ? {1'b0, 4'(k)} : {1'b1, 4'(k - 15)});
        k++;
      end
      if (done2) seen = 1'b1;
    end
    check("rt_rounds", k, 30);
    check("rt_latency", n, 34);
    check("rt_result", {assert2, fail_cnt2}, {1'b1, 5'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
